uart_frame_loader: RTL and testbench

//  Sits between the UART byte receiver and the layer-scan driver in lightcube8_top.

---
 rtl/uart_frame_loader.sv | 126 ++++++++++++
 tb/tb_uart_frame_loader.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_loader.sv
// Collects a stream of received UART bytes into a ping-pong frame buffer and exposes
// only complete frames to the layer scanner through a registered read port.
module uart_frame_loader #(
    parameter  int FRAME_BYTES    = 64,
    parameter  int TIMEOUT_CYCLES = 260400,
    parameter  int TMR_W          = 19,
    localparam int IDX_W          = $clog2(FRAME_BYTES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_err,
    input  logic             err_clr,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [7:0]       rd_data,
    output logic             frame_done,
    output logic [7:0]       frame_cnt,
    output logic             err_sticky,
    output logic             busy
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_bank;
    logic [TMR_W-1:0] timer;
    logic [7:0]       bank [2][FRAME_BYTES];

    logic accept, bad_byte;
    logic wr_en, commit, timed_out, err_set, timer_run;

    assign accept   = enable && rx_valid && !rx_err;
    assign bad_byte = enable && rx_valid && rx_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An accepted byte always beats a timer expiry on the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = FILL;
            end
            FILL: begin
                if (!enable || bad_byte)  state_nxt = IDLE;
                else if (accept)          state_nxt = (wr_idx == LAST_IDX) ? IDLE : FILL;
                else if (timer == TMR_MAX) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_en     = accept;
        commit    = (state == FILL) && accept && (wr_idx == LAST_IDX);
        timed_out = (state == FILL) && enable && !rx_valid && (timer == TMR_MAX);
        err_set   = bad_byte || timed_out;
        timer_run = (state == FILL) && (state_nxt == FILL) && !accept;
        busy      = (state == FILL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx     <= '0;
            wr_bank    <= 1'b0;
            timer      <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
            err_sticky <= 1'b0;
        end else begin
            if (!enable || bad_byte || commit || timed_out) begin
                wr_idx <= '0;
            end else if (accept) begin
                wr_idx <= wr_idx + IDX_W'(1);
            end

            if (!timer_run) begin
                timer <= '0;
            end else if (timer != TMR_MAX) begin
                timer <= timer + TMR_W'(1);
            end

            wr_bank    <= wr_bank ^ commit;
            frame_done <= commit;
            if (commit) begin
                frame_cnt <= frame_cnt + 8'd1;
            end

            if (err_set) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

    // The display bank (~wr_bank) is never written, so a torn frame cannot be shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < FRAME_BYTES; i++) begin
                    bank[b][i] <= 8'h00;
                end
            end
            rd_data <= 8'h00;
        end else begin
            if (wr_en) begin
                bank[wr_bank][wr_idx] <= rx_data;
            end
            rd_data <= bank[~wr_bank][rd_addr];
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Randomized bench for uart_frame_loader; a queue-based frame model decides what the
// scanner should see, when frames commit and when partial frames are discarded.
module tb_uart_frame_loader;

    localparam int T = 200;
    localparam int N = 64;

    logic       clk = 1'b0;
    logic       rst, enable, rx_valid, rx_err, err_clr;
    logic [7:0] rx_data;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_done;
    logic [7:0] frame_cnt;
    logic       err_sticky;
    logic       busy;

    uart_frame_loader #(.FRAME_BYTES(N), .TIMEOUT_CYCLES(T), .TMR_W(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_err(rx_err), .err_clr(err_clr), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .err_sticky(err_sticky), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int done_seen = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (frame_done === 1'b1) done_seen <= done_seen + 1;
    end

    // Reference model: visible frame, bytes of the frame being collected, expected counters
    logic [7:0] disp [N];
    logic [7:0] pending [$];
    int  exp_cnt, exp_done, last_acc;
    bit  exp_err;
    int  total = 0;
    int  bad = 0;

    task automatic model_reset();
        for (int i = 0; i < N; i++) disp[i] = 8'h00;
        pending.delete();
        exp_cnt = 0;
        exp_err = 0;
    endtask

    task automatic model_expire();
        if (pending.size() > 0 && cyc - last_acc >= T) begin
            pending.delete();
            exp_err = 1;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the byte was sampled.
    task automatic send_byte(input logic [7:0] d, input logic e);
        model_expire();
        rx_valid = 1'b1;
        rx_data  = d;
        rx_err   = e;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        if (enable) begin
            if (e) begin
                pending.delete();
                exp_err = 1;
            end else begin
                pending.push_back(d);
                last_acc = cyc;
                if (pending.size() == N) begin
                    for (int i = 0; i < N; i++) disp[i] = pending[i];
                    pending.delete();
                    exp_cnt++;
                    exp_done++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_enable(input logic v);
        enable = v;
        if (!v) pending.delete();
        @(negedge clk);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = 0;
    endtask

    task automatic send_frame(input logic [7:0] seed, input bit rnd, input int maxgap);
        for (int j = 0; j < N; j++) begin
            idle($urandom_range(0, maxgap));
            send_byte(rnd ? 8'($urandom) : (seed ^ 8'(j)), 1'b0);
        end
    endtask

    task automatic read_display(output int nbad, output int first);
        nbad  = 0;
        first = -1;
        for (int a = 0; a < N; a++) begin
            rd_addr = 6'(a);
            @(negedge clk);
            if (rd_data !== disp[a]) begin
                nbad++;
                if (first < 0) first = a;
            end
        end
    endtask

    task automatic test_reset();
        int nb, fa;
        rst = 1'b1; enable = 1'b1; rx_valid = 1'b0; rx_err = 1'b0; err_clr = 1'b0;
        rx_data = 8'h00; rd_addr = 6'd0;
        model_reset();
        exp_done = 0;
        last_acc = 0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({rd_data, frame_done, frame_cnt, err_sticky, busy} !== 19'd0) begin
            $display("[TB] FAIL reset_outputs: got rd=%h done=%b cnt=%0d err=%b busy=%b, want all zero",
                     rd_data, frame_done, frame_cnt, err_sticky, busy);
            bad++;
        end
        read_display(nb, fa);
        total++;
        if (nb !== 0) begin
            $display("[TB] FAIL reset_display: %0d bad bytes (first addr %0d), want 0", nb, fa);
            bad++;
        end
    endtask

    task automatic test_single_frame();
        int nb, fa;
        send_frame(8'h00, 1'b0, 3);
        read_display(nb, fa);
        total++;
        if (nb !== 0) begin
            $display("[TB] FAIL single_display: %0d bad bytes (first addr %0d), want 0", nb, fa);
            bad++;
        end
        total++;
        if (frame_cnt !== 8'(exp_cnt) || err_sticky !== exp_err || done_seen !== exp_done) begin
            $display("[TB] FAIL single_status: cnt=%0d err=%b done=%0d, want cnt=%0d err=%b done=%0d",
                     frame_cnt, err_sticky, done_seen, 8'(exp_cnt), exp_err, exp_done);
            bad++;
        end
    endtask

    task automatic test_frames();
        int nb, fa;
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 32) begin
                    read_display(nb, fa);
                    total++;
                    if (nb !== 0 || busy !== 1'b1) begin
                        $display("[TB] FAIL midfill_frame%0d: %0d bad bytes (first %0d) busy=%b, want 0 bad busy=1",
                                 i, nb, fa, busy);
                        bad++;
                    end
                end
                idle($urandom_range(0, 4));
                send_byte((i < 10) ? (8'(i) ^ 8'(j)) : 8'($urandom), 1'b0);
            end
            idle(T + 10);
        end
        model_expire();
        read_display(nb, fa);
        total++;
        if (nb !== 0 || frame_cnt !== 8'(exp_cnt) || done_seen !== exp_done || err_sticky !== exp_err) begin
            $display("[TB] FAIL frames_final: bad=%0d cnt=%0d done=%0d err=%b, want bad=0 cnt=%0d done=%0d err=%b",
                     nb, frame_cnt, done_seen, err_sticky, 8'(exp_cnt), exp_done, exp_err);
            bad++;
        end
    endtask

    task automatic test_timeout();
        int nb, fa;
        int cnt0;
        cnt0 = exp_cnt;
        for (int j = 0; j < 20; j++) send_byte(8'($urandom), 1'b0);
        idle(T + 3);
        model_expire();
        total++;
        if (err_sticky !== 1'b1 || busy !== 1'b0 || frame_cnt !== 8'(cnt0) || exp_err !== 1'b1) begin
            $display("[TB] FAIL timeout_discard: err=%b busy=%b cnt=%0d, want err=1 busy=0 cnt=%0d",
                     err_sticky, busy, frame_cnt, 8'(cnt0));
            bad++;
        end
        pulse_err_clr();
        total++;
        if (err_sticky !== 1'b0) begin
            $display("[TB] FAIL timeout_clear: err=%b, want 0", err_sticky);
            bad++;
        end
        // Gap one short of the limit must survive; a gap at the limit must discard.
        for (int j = 0; j < N; j++) begin
            if (j == 10) idle(T - 1);
            send_byte(8'($urandom), 1'b0);
        end
        total++;
        if (err_sticky !== exp_err || frame_cnt !== 8'(exp_cnt) || exp_cnt !== cnt0 + 1) begin
            $display("[TB] FAIL timeout_edge_keep: err=%b cnt=%0d, want err=0 cnt=%0d",
                     err_sticky, frame_cnt, 8'(cnt0 + 1));
            bad++;
        end
        for (int j = 0; j < 5; j++) send_byte(8'($urandom), 1'b0);
        idle(T);
        send_frame(8'h00, 1'b1, 2);
        read_display(nb, fa);
        total++;
        if (nb !== 0 || err_sticky !== 1'b1 || frame_cnt !== 8'(exp_cnt) || done_seen !== exp_done) begin
            $display("[TB] FAIL timeout_edge_drop: bad=%0d err=%b cnt=%0d done=%0d, want bad=0 err=1 cnt=%0d done=%0d",
                     nb, err_sticky, frame_cnt, done_seen, 8'(exp_cnt), exp_done);
            bad++;
        end
        pulse_err_clr();
    endtask

    task automatic test_rx_err();
        int nb, fa;
        for (int j = 0; j < 30; j++) send_byte(8'($urandom), 1'b0);
        send_byte(8'hA5, 1'b1);
        total++;
        if (err_sticky !== 1'b1 || busy !== 1'b0) begin
            $display("[TB] FAIL rxerr_discard: err=%b busy=%b, want err=1 busy=0", err_sticky, busy);
            bad++;
        end
        pulse_err_clr();
        total++;
        if (err_sticky !== 1'b0) begin
            $display("[TB] FAIL rxerr_clear: err=%b, want 0", err_sticky);
            bad++;
        end
        send_frame(8'h00, 1'b1, 3);
        read_display(nb, fa);
        total++;
        if (nb !== 0 || frame_cnt !== 8'(exp_cnt) || err_sticky !== 1'b0) begin
            $display("[TB] FAIL rxerr_recover: bad=%0d cnt=%0d err=%b, want bad=0 cnt=%0d err=0",
                     nb, frame_cnt, err_sticky, 8'(exp_cnt));
            bad++;
        end
        for (int j = 0; j < 5; j++) send_byte(8'($urandom), 1'b0);
        err_clr = 1'b1;
        send_byte(8'h3C, 1'b1);
        err_clr = 1'b0;
        total++;
        if (err_sticky !== 1'b1) begin
            $display("[TB] FAIL rxerr_set_wins: err=%b, want 1", err_sticky);
            bad++;
        end
        pulse_err_clr();
    endtask

    task automatic test_enable();
        int nb, fa;
        set_enable(1'b0);
        for (int j = 0; j < N; j++) send_byte(8'($urandom), 1'($urandom_range(0, 7) == 0));
        read_display(nb, fa);
        total++;
        if (nb !== 0 || frame_cnt !== 8'(exp_cnt) || err_sticky !== 1'b0 || busy !== 1'b0) begin
            $display("[TB] FAIL enable_off: bad=%0d cnt=%0d err=%b busy=%b, want bad=0 cnt=%0d err=0 busy=0",
                     nb, frame_cnt, err_sticky, busy, 8'(exp_cnt));
            bad++;
        end
        set_enable(1'b1);
        for (int j = 0; j < 10; j++) send_byte(8'($urandom), 1'b0);
        set_enable(1'b0);
        idle(2);
        total++;
        if (busy !== 1'b0) begin
            $display("[TB] FAIL enable_drop_busy: busy=%b, want 0", busy);
            bad++;
        end
        set_enable(1'b1);
        send_frame(8'h00, 1'b1, 2);
        read_display(nb, fa);
        total++;
        if (nb !== 0 || frame_cnt !== 8'(exp_cnt) || err_sticky !== 1'b0 || done_seen !== exp_done) begin
            $display("[TB] FAIL enable_refill: bad=%0d cnt=%0d err=%b done=%0d, want bad=0 cnt=%0d err=0 done=%0d",
                     nb, frame_cnt, err_sticky, done_seen, 8'(exp_cnt), exp_done);
            bad++;
        end
    endtask

    task automatic test_commit_read();
        logic [7:0] old5;
        old5 = disp[5];
        rd_addr = 6'd5;
        for (int j = 0; j < N - 1; j++) send_byte((j == 5) ? ~old5 : 8'($urandom), 1'b0);
        send_byte(8'($urandom), 1'b0);
        total++;
        if (rd_data !== old5 || frame_done !== 1'b1) begin
            $display("[TB] FAIL commit_old_read: rd=%h done=%b, want rd=%h done=1", rd_data, frame_done, old5);
            bad++;
        end
        @(negedge clk);
        total++;
        if (rd_data !== disp[5] || rd_data !== ~old5 || frame_done !== 1'b0) begin
            $display("[TB] FAIL commit_new_read: rd=%h done=%b, want rd=%h done=0", rd_data, frame_done, ~old5);
            bad++;
        end
    endtask

    task automatic test_reset_mid();
        int nb, fa;
        send_byte(8'h11, 1'b1);
        for (int j = 0; j < 20; j++) send_byte(8'($urandom), 1'b0);
        rd_addr = 6'd5;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({rd_data, frame_done, frame_cnt, err_sticky, busy} !== 19'd0) begin
            $display("[TB] FAIL reset_mid: rd=%h done=%b cnt=%0d err=%b busy=%b, want all zero",
                     rd_data, frame_done, frame_cnt, err_sticky, busy);
            bad++;
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        send_frame(8'h5A, 1'b0, 2);
        read_display(nb, fa);
        total++;
        if (nb !== 0 || frame_cnt !== 8'd1 || exp_cnt !== 1 || err_sticky !== 1'b0) begin
            $display("[TB] FAIL reset_recover: bad=%0d cnt=%0d err=%b, want bad=0 cnt=1 err=0",
                     nb, frame_cnt, err_sticky);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_frames();
        test_timeout();
        test_rx_err();
        test_enable();
        test_commit_read();
        test_reset_mid();
        idle(2);
        total++;
        if (done_seen !== exp_done) begin
            $display("[TB] FAIL done_pulses: seen=%0d, want %0d", done_seen, exp_done);
            bad++;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
